hazard_ctrl_unit: RTL

Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM write enables, the ID control-bubble mux and the IF/ID and ID/EX flush lines. Compared with the single-cycle load-use detector, it adds configurable load latency, $zero filtering, multi-cycle branch flush and a data-memory wait freeze with timeout. All of these are coordinated by a small FSM with counters.

---
 rtl/hazard_ctrl_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - 5-stage pipeline hazard controller (load-use, branch flush, memory wait)
// HAZARD_PERF_EN builds the saturating stall/flush performance counters
module hazard_ctrl_unit #(
   parameter int REG_AW      = 5,
   parameter int OPC_W       = 6,
   parameter int RTYPE_OPC   = 0,
   parameter int LOAD_LAT    = 1,
   parameter int BR_PENALTY  = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IDEX_MemRead,
   input  logic [REG_AW-1:0] IDEXregRt,
   input  logic              EXMEM_MemRead,
   input  logic [REG_AW-1:0] EXMEMregRt,
   input  logic [REG_AW-1:0] IFIDregRs,
   input  logic [REG_AW-1:0] IFIDregRt,
   input  logic [OPC_W-1:0]  IDopcode,
   input  logic              EX_BranchTaken,
   input  logic              MEM_Req,
   input  logic              MEM_Ready,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              IDEXWrite,
   output logic              EXMEMWrite,
   output logic              controlmux,
   output logic              IFIDFlush,
   output logic              IDEXFlush,
   output logic              MemTimeout,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount
);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_WAIT} state_t;

   localparam logic       LAT2     = (LOAD_LAT >= 2);
   localparam logic [2:0] REM_LOAD = 3'(BR_PENALTY - 1);
   localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);

   state_t     r_state, w_next;
   logic [2:0] r_rem, w_rem_next;
   logic [7:0] r_wait, w_wait_next;
   logic       r_timeout, w_timeout_next;

   logic w_rtype, w_hit_ex, w_hit_mem, w_lu, w_freeze, w_flushing;

   assign w_rtype   = (IDopcode == OPC_W'(RTYPE_OPC));
   assign w_hit_ex  = IDEX_MemRead && (IDEXregRt != '0) &&
                      ((IDEXregRt == IFIDregRs) || (w_rtype && (IDEXregRt == IFIDregRt)));
   assign w_hit_mem = EXMEM_MemRead && (EXMEMregRt != '0) &&
                      ((EXMEMregRt == IFIDregRs) || (w_rtype && (EXMEMregRt == IFIDregRt)));
   assign w_lu      = w_hit_ex | (LAT2 & w_hit_mem);
   assign w_freeze  = MEM_Req & ~MEM_Ready;
   // Leaving WAIT resumes whichever of RUN/FLUSH was interrupted, judged by the preserved count.
   assign w_flushing = (r_state == S_FLUSH) || ((r_state == S_WAIT) && (r_rem != 3'd0));

   always_comb begin
      w_next         = r_state;
      w_rem_next     = r_rem;
      w_wait_next    = 8'd0;
      w_timeout_next = r_timeout;
      PCWrite        = 1'b1;
      IFIDWrite      = 1'b1;
      IDEXWrite      = 1'b1;
      EXMEMWrite     = 1'b1;
      controlmux     = 1'b1;
      IFIDFlush      = 1'b0;
      IDEXFlush      = 1'b0;
      if (w_freeze) begin
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
         IDEXWrite   = 1'b0;
         EXMEMWrite  = 1'b0;
         w_next      = S_WAIT;
         w_wait_next = (r_wait == TMO) ? TMO : r_wait + 8'd1;
         if (r_wait >= TMO - 8'd1)
            w_timeout_next = 1'b1;
      end else if (EX_BranchTaken) begin
         IFIDFlush  = 1'b1;
         IDEXFlush  = 1'b1;
         w_rem_next = REM_LOAD;
         w_next     = (REM_LOAD != 3'd0) ? S_FLUSH : S_RUN;
      end else if (w_flushing) begin
         IFIDFlush  = 1'b1;
         w_rem_next = r_rem - 3'd1;
         w_next     = (r_rem == 3'd1) ? S_RUN : S_FLUSH;
      end else begin
         w_next = S_RUN;
         if (w_lu) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            controlmux = 1'b0;
         end
      end
      // Outputs must read as idle for the whole reset window, whatever the inputs do.
      if (!rst_n) begin
         PCWrite    = 1'b1;
         IFIDWrite  = 1'b1;
         IDEXWrite  = 1'b1;
         EXMEMWrite = 1'b1;
         controlmux = 1'b1;
         IFIDFlush  = 1'b0;
         IDEXFlush  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RUN;
         r_rem     <= 3'd0;
         r_wait    <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_rem     <= w_rem_next;
         r_wait    <= w_wait_next;
         r_timeout <= w_timeout_next;
      end
   end

   assign MemTimeout = r_timeout;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!PCWrite && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (IFIDFlush && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule
